// File: rtl/imem_loader.sv
// Framed byte-stream program loader: assembles little-endian words, writes them
// into instruction memory and holds the core in reset until a good checksum arrives.
module imem_loader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t state, state_nxt;

  logic [15:0]         len;
  logic [ADDR_WIDTH:0] word_index;
  logic [1:0]          byte_cnt;
  logic [7:0]          acc;
  logic [31:0]         word_reg;

  logic        fire;
  logic [15:0] len_full;
  logic        len_over;
  logic        len_zero;
  logic        last_word;

  assign fire      = byte_valid && byte_ready;
  assign len_full  = {byte_data, len[7:0]};
  assign len_over  = 32'(len_full) > DEPTH;
  assign len_zero  = (len_full == 16'd0);
  // word_index is one bit wider than the address so N == DEPTH ends without wrapping
  assign last_word = ({1'b0, len} == (17'(word_index) + 17'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LEN0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LEN0: begin
        if (fire) state_nxt = LEN1;
      end
      LEN1: begin
        if (fire) begin
          if (len_over)      state_nxt = ERROR;
          else if (len_zero) state_nxt = CHECK;
          else               state_nxt = DATA;
        end
      end
      DATA: begin
        if (fire && byte_cnt == 2'd3 && last_word) state_nxt = CHECK;
      end
      CHECK: begin
        if (fire) state_nxt = (byte_data == acc) ? DONE : ERROR;
      end
      DONE, ERROR: begin
        if (start) state_nxt = LEN0;
      end
      default: state_nxt = LEN0;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state)
      LEN0, LEN1, DATA, CHECK: byte_ready = 1'b1;
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ERROR:   err = 1'b1;
      default: byte_ready = 1'b0;
    endcase
  end

  // Datapath: length capture, word assembly, checksum and the registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len        <= '0;
      word_index <= '0;
      byte_cnt   <= '0;
      acc        <= '0;
      word_reg   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
    end else begin
      mem_we <= 1'b0;
      if (fire) begin
        unique case (state)
          LEN0: len[7:0] <= byte_data;
          LEN1: begin
            // Counters are cleared for every length, so an empty frame checks against 0
            len[15:8]  <= byte_data;
            word_index <= '0;
            byte_cnt   <= '0;
            acc        <= '0;
          end
          DATA: begin
            acc                     <= acc ^ byte_data;
            byte_cnt                <= byte_cnt + 2'd1;
            word_reg[8*byte_cnt +: 8] <= byte_data;
            if (byte_cnt == 2'd3) begin
              mem_we     <= 1'b1;
              mem_addr   <= WIDTH'({word_index[ADDR_WIDTH-1:0], 2'b00});
              mem_wd     <= WIDTH'({byte_data, word_reg[23:0]});
              word_index <= word_index + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum/length errors, stalls and reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_wd[$];
  int          run = 0;
  int          max_run = 0;

  logic [7:0] frame_good[11] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                                 8'h6F, 8'h00, 8'h00, 8'h00, 8'hD9};

  imem_loader #(.WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_wd.push_back(mem_wd);
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Presents one byte after `gap` idle cycles; returns just after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(posedge clk);
    #1;
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=%h expected=%h", byte_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_good(input logic [7:0] last, input bit stall);
    for (int i = 0; i < 10; i++) send(frame_good[i], stall ? $urandom_range(0, 5) : 0);
    send(last, stall ? $urandom_range(0, 5) : 0);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_log;
    wq_addr.delete();
    wq_wd.delete();
    max_run = 0;
  endtask

  task automatic chk_two_writes(input string tag);
    chk({tag, "_nwr"}, wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      chk({tag, "_a0"}, wq_addr[0], 32'h0);
      chk({tag, "_d0"}, wq_wd[0], 32'h00A00513);
      chk({tag, "_a1"}, wq_addr[1], 32'h4);
      chk({tag, "_d1"}, wq_wd[1], 32'h0000006F);
    end
    chk({tag, "_we_width"}, max_run, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, byte_ready, 1);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wd"}, mem_wd, 0);
    chk({tag, "_hold"}, cpu_hold, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #2;
    chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic load
    clear_log();
    send_good(8'hD9, 1'b0);
    chk("basic_done", done, 1);
    chk("basic_hold", cpu_hold, 0);
    chk("basic_err", err, 0);
    chk("basic_ready", byte_ready, 0);
    chk_two_writes("basic");
    chk("basic_last_wd", mem_wd, 32'h0000006F);

    // Re-arm, then bad checksum
    pulse_start();
    chk("rearm_ready", byte_ready, 1);
    chk("rearm_done", done, 0);
    chk("rearm_hold", cpu_hold, 1);
    clear_log();
    send_good(8'hD8, 1'b0);
    chk("badchk_err", err, 1);
    chk("badchk_hold", cpu_hold, 1);
    chk("badchk_ready", byte_ready, 0);
    chk("badchk_done", done, 0);
    chk_two_writes("badchk");

    // Empty program
    pulse_start();
    clear_log();
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("empty_done", done, 1);
    chk("empty_nwr", wq_addr.size(), 0);
    pulse_start();
    chk("empty_rearm_done", done, 0);
    chk("empty_rearm_hold", cpu_hold, 1);
    chk("empty_rearm_ready", byte_ready, 1);

    // Oversize length, N = 257
    clear_log();
    send(8'h01, 0);
    send(8'h01, 0);
    chk("over_err", err, 1);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (5) @(posedge clk);
    #1;
    chk("over_ready", byte_ready, 0);
    chk("over_err_hold", err, 1);
    chk("over_nwr", wq_addr.size(), 0);
    byte_valid = 1'b0;

    // Random valid gaps
    pulse_start();
    clear_log();
    send_good(8'hD9, 1'b1);
    chk("stall_done", done, 1);
    chk("stall_hold", cpu_hold, 0);
    chk_two_writes("stall");

    // Reset in the middle of the first word
    pulse_start();
    clear_log();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h05, 0);
    rst = 1'b0;
    #2;
    chk_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_good(8'hD9, 1'b0);
    chk("midrst_done", done, 1);
    chk("midrst_hold", cpu_hold, 0);
    chk_two_writes("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
